// File: rtl/sync_fifo_if.sv
// Handshake bundle for sync_fifo. The o_count signal exists only when
// SYNC_FIFO_COUNT_EN is defined.
interface sync_fifo_if #(
    parameter int DataWidth = 8,
    parameter int Depth     = 8
);
    // A write is taken at a rising edge when i_wr_en is high and the FIFO is
    // not full (or a read is taken in the same cycle). A read is taken when
    // i_rd_en is high and the FIFO is not empty. o_rd_data shows the head
    // word before the popping edge.
    logic [DataWidth-1:0]     i_wr_data;
    logic                     i_wr_en;
    logic                     i_rd_en;
    logic [DataWidth-1:0]     o_rd_data;
    logic                     o_full;
    logic                     o_empty;
`ifdef SYNC_FIFO_COUNT_EN
    logic [$clog2(Depth):0]   o_count;

    modport slave (
        input  i_wr_data, i_wr_en, i_rd_en,
        output o_rd_data, o_full, o_empty, o_count
    );
    modport master (
        output i_wr_data, i_wr_en, i_rd_en,
        input  o_rd_data, o_full, o_empty, o_count
    );
`else
    modport slave (
        input  i_wr_data, i_wr_en, i_rd_en,
        output o_rd_data, o_full, o_empty
    );
    modport master (
        output i_wr_data, i_wr_en, i_rd_en,
        input  o_rd_data, o_full, o_empty
    );
`endif
endinterface

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO with a power-of-two circular buffer.
// Define SYNC_FIFO_COUNT_EN to add the o_count occupancy port.
module sync_fifo #(
    parameter int DataWidth = 8,
    parameter int Depth     = 8
) (
    input logic        i_clk,
    input logic        i_rst,
    sync_fifo_if.slave fifo
);
    localparam int AW = $clog2(Depth);
    localparam logic [AW:0] PtrOne = {{AW{1'b0}}, 1'b1};

    logic [AW:0]          wr_ptr_q, wr_ptr_d;
    logic [AW:0]          rd_ptr_q, rd_ptr_d;
    logic [DataWidth-1:0] mem_q [Depth];
    logic [DataWidth-1:0] mem_d [Depth];
    logic                 empty;
    logic                 full;
    logic                 rd_accept;
    logic                 wr_accept;

    // Pointers carry one extra wrap bit so equal addresses can be told apart:
    // same wrap bit means empty, opposite wrap bit means full.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                   (wr_ptr_q[AW] != rd_ptr_q[AW]);

    assign rd_accept = fifo.i_rd_en && !empty;
    assign wr_accept = fifo.i_wr_en && (!full || rd_accept);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (wr_accept) begin
            mem_d[wr_ptr_q[AW-1:0]] = fifo.i_wr_data;
            wr_ptr_d                = wr_ptr_q + PtrOne;
        end
        if (rd_accept) begin
            rd_ptr_d = rd_ptr_q + PtrOne;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is not reset; stale entries are unreachable once pointers clear.
    always_ff @(posedge i_clk) begin
        mem_q <= mem_d;
    end

    assign fifo.o_rd_data = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    assign fifo.o_full    = full;
    assign fifo.o_empty   = empty;
`ifdef SYNC_FIFO_COUNT_EN
    assign fifo.o_count   = wr_ptr_q - rd_ptr_q;
`endif
endmodule

// File: tb/tb_sync_fifo.sv
// Directed and random checks of sync_fifo against a queue model of FIFO
// behaviour.
module tb_sync_fifo;
    localparam int DW = 8;
    localparam int DEPTH = 8;

    logic i_clk;
    logic i_rst;
    int   n_checks;
    int   n_fail;
    logic [DW-1:0] model_q[$];

    sync_fifo_if #(.DataWidth(DW), .Depth(DEPTH)) fifo_if();

    sync_fifo #(.DataWidth(DW), .Depth(DEPTH)) u_dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .fifo  (fifo_if.slave)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        logic [DW-1:0] head;
        head = (model_q.size() == 0) ? '0 : model_q[0];
        chk({tag, ".empty"}, {31'd0, fifo_if.o_empty}, {31'd0, model_q.size() == 0});
        chk({tag, ".full"}, {31'd0, fifo_if.o_full}, {31'd0, model_q.size() == DEPTH});
        chk({tag, ".head"}, {24'd0, fifo_if.o_rd_data}, {24'd0, head});
`ifdef SYNC_FIFO_COUNT_EN
        chk({tag, ".count"}, {28'd0, fifo_if.o_count}, model_q.size());
`endif
    endtask

    // One clock: inputs applied now, edge taken, model updated, outputs checked.
    task automatic cycle(input logic wr, input logic [DW-1:0] data, input logic rd,
                         input string tag);
        bit rd_ok, wr_ok;
        fifo_if.i_wr_en   = wr;
        fifo_if.i_wr_data = data;
        fifo_if.i_rd_en   = rd;
        rd_ok = rd && (model_q.size() > 0);
        wr_ok = wr && ((model_q.size() < DEPTH) || rd_ok);
        @(posedge i_clk);
        #1;
        if (rd_ok) void'(model_q.pop_front());
        if (wr_ok) model_q.push_back(data);
        fifo_if.i_wr_en = 1'b0;
        fifo_if.i_rd_en = 1'b0;
        check_model(tag);
    endtask

    task automatic do_reset(input logic wr_during);
        i_rst = 1'b1;
        fifo_if.i_wr_en   = wr_during;
        fifo_if.i_rd_en   = wr_during;
        fifo_if.i_wr_data = 8'hEE;
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        fifo_if.i_wr_en = 1'b0;
        fifo_if.i_rd_en = 1'b0;
        model_q.delete();
        check_model("reset");
    endtask

    initial begin
        logic [DW-1:0] v;
        n_checks = 0;
        n_fail   = 0;
        i_rst = 1'b1;
        fifo_if.i_wr_en   = 1'b0;
        fifo_if.i_rd_en   = 1'b0;
        fifo_if.i_wr_data = '0;
        @(posedge i_clk);
        #1;
        do_reset(1'b0);
        chk("rst_empty", {31'd0, fifo_if.o_empty}, 32'd1);
        chk("rst_full", {31'd0, fifo_if.o_full}, 32'd0);
        chk("rst_data", {24'd0, fifo_if.o_rd_data}, 32'd0);

        // Burst fill, dropped overflow write, burst drain.
        for (int i = 1; i <= 8; i++) begin
            v = DW'(8'h11 * i);
            cycle(1'b1, v, 1'b0, "fill");
        end
        chk("fill_full", {31'd0, fifo_if.o_full}, 32'd1);
        cycle(1'b1, 8'h99, 1'b0, "overflow");
        chk("overflow_head", {24'd0, fifo_if.o_rd_data}, 32'h11);
        for (int i = 1; i <= 8; i++) begin
            chk("drain_pop", {24'd0, fifo_if.o_rd_data}, 32'h11 * i);
            cycle(1'b0, 8'h00, 1'b1, "drain");
        end
        chk("drain_empty", {31'd0, fifo_if.o_empty}, 32'd1);
        chk("drain_zero", {24'd0, fifo_if.o_rd_data}, 32'd0);

        // Isolated writes then isolated reads with idle gaps.
        for (int i = 0; i < 8; i++) begin
            v = DW'(8'hA0 + i);
            cycle(1'b1, v, 1'b0, "iso_wr");
            cycle(1'b0, 8'h00, 1'b0, "iso_idle");
        end
        for (int i = 0; i < 8; i++) begin
            chk("iso_pop", {24'd0, fifo_if.o_rd_data}, 32'hA0 + i);
            cycle(1'b0, 8'h00, 1'b1, "iso_rd");
            cycle(1'b0, 8'h00, 1'b0, "iso_idle");
        end

        // Streaming: each read returns the previous write.
        cycle(1'b1, 8'h01, 1'b0, "stream_first");
        for (int i = 2; i <= 8; i++) begin
            v = DW'(i);
            chk("stream_pop", {24'd0, fifo_if.o_rd_data}, i - 1);
            cycle(1'b1, v, 1'b1, "stream");
            chk("stream_notfull", {31'd0, fifo_if.o_full}, 32'd0);
        end
        chk("stream_last", {24'd0, fifo_if.o_rd_data}, 32'h08);
        cycle(1'b0, 8'h00, 1'b1, "stream_end");
        chk("stream_empty", {31'd0, fifo_if.o_empty}, 32'd1);

        // Simultaneous read and write while full.
        for (int i = 0; i < 8; i++) begin
            v = DW'($urandom_range(0, 254));
            cycle(1'b1, v, 1'b0, "full_fill");
        end
        cycle(1'b1, 8'hFF, 1'b1, "full_rw");
        chk("full_rw_full", {31'd0, fifo_if.o_full}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            if (i == 7) chk("full_rw_last", {24'd0, fifo_if.o_rd_data}, 32'hFF);
            cycle(1'b0, 8'h00, 1'b1, "full_drain");
        end

        // Read on empty is ignored.
        cycle(1'b0, 8'h00, 1'b1, "empty_rd");
        cycle(1'b1, 8'h5A, 1'b0, "after_empty_wr");
        chk("after_empty_head", {24'd0, fifo_if.o_rd_data}, 32'h5A);
        cycle(1'b0, 8'h00, 1'b1, "after_empty_rd");

        // Mid-operation reset with enables high discards contents.
        cycle(1'b1, 8'h31, 1'b0, "pre_rst");
        cycle(1'b1, 8'h32, 1'b0, "pre_rst");
        cycle(1'b1, 8'h33, 1'b0, "pre_rst");
        do_reset(1'b1);
        chk("mid_rst_empty", {31'd0, fifo_if.o_empty}, 32'd1);
        chk("mid_rst_full", {31'd0, fifo_if.o_full}, 32'd0);
        cycle(1'b1, 8'h3C, 1'b0, "post_rst");
        chk("post_rst_head", {24'd0, fifo_if.o_rd_data}, 32'h3C);

        // Random traffic with occasional resets.
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 79) == 0) begin
                do_reset(1'($urandom_range(0, 1)));
            end else begin
                v = DW'($urandom);
                cycle(1'($urandom_range(0, 2) != 0), v, 1'($urandom_range(0, 2) != 0),
                      "random");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
